// File: rtl/run_detect_ctrl.sv
// run_detect_ctrl: configurable windowed run detector
// with config validation and start/done handshake.
module run_detect_ctrl #(
   parameter int LEN_W = 4,
   parameter int WIN_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [1:0]       cfg_mode,
   input  logic [WIN_W-1:0] cfg_win,
   input  logic             start,
   input  logic             abort,
   input  logic             x,
   input  logic             x_valid,
   output logic             busy,
   output logic             y,
   output logic             done,
   output logic [CNT_W-1:0] hit_cnt,
   output logic             cfg_err
);

   typedef enum logic [1:0] {
      ST_ARMED = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [LEN_W-1:0] run_len_q, run_len_d;
   logic             last_bit_q, last_bit_d;
   logic [WIN_W:0]   bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic             y_q, y_d;
   logic             done_q, done_d;
   logic             cfg_err_q, cfg_err_d;
   logic             busy_q, busy_d;
   logic             cfg_ready_q, cfg_ready_d;

   logic             cfg_ok;
   logic [LEN_W-1:0] run_nxt;
   logic             pol_ok;
   logic             hit;
   logic [WIN_W:0]   win_tgt;
   logic [WIN_W:0]   bit_inc;

   // A window of 0 stands for the full 2^WIN_W samples.
   assign cfg_ok  = (cfg_len >= LEN_W'(2)) && (cfg_mode != 2'b00);
   assign win_tgt = (win_q == '0) ? {1'b1, {WIN_W{1'b0}}}
                                  : {1'b0, win_q};
   assign bit_inc = bit_cnt_q + (WIN_W+1)'(1);

   // Evaluate the current sample: run length saturates at len.
   always_comb begin
      run_nxt = LEN_W'(1);
      if ((run_len_q != '0) && (x == last_bit_q)) begin
         if (run_len_q >= len_q) begin
            run_nxt = len_q;
         end else begin
            run_nxt = run_len_q + LEN_W'(1);
         end
      end
      pol_ok = x ? mode_q[0] : mode_q[1];
      hit    = (run_nxt == len_q) && pol_ok;
   end

   // Next-state, config latch and counter updates.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      mode_d     = mode_q;
      win_d      = win_q;
      run_len_d  = run_len_q;
      last_bit_d = last_bit_q;
      bit_cnt_d  = bit_cnt_q;
      hit_cnt_d  = hit_cnt_q;
      y_d        = 1'b0;
      cfg_err_d  = 1'b0;
      unique case (state_q)
         ST_ARMED: begin
            if (cfg_valid) begin
               if (cfg_ok) begin
                  len_d  = cfg_len;
                  mode_d = cfg_mode;
                  win_d  = cfg_win;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
            if (start) begin
               state_d   = ST_RUN;
               hit_cnt_d = '0;
               run_len_d = '0;
               bit_cnt_d = '0;
            end
         end
         ST_RUN: begin
            if (x_valid) begin
               run_len_d  = run_nxt;
               last_bit_d = x;
               y_d        = hit;
               bit_cnt_d  = bit_inc;
               if (hit && (hit_cnt_q != {CNT_W{1'b1}})) begin
                  hit_cnt_d = hit_cnt_q + CNT_W'(1);
               end
               if (bit_inc == win_tgt) begin
                  state_d = ST_DONE;
               end
            end
            // Abort beats a coincident last sample.
            if (abort) begin
               state_d = ST_ARMED;
            end
         end
         ST_DONE: begin
            state_d = ST_ARMED;
         end
         default: begin
            state_d = ST_ARMED;
         end
      endcase
      busy_d      = (state_d == ST_RUN);
      cfg_ready_d = (state_d == ST_ARMED);
      done_d      = (state_d == ST_DONE);
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ARMED;
         len_q       <= LEN_W'(3);
         mode_q      <= 2'b11;
         win_q       <= '0;
         run_len_q   <= '0;
         last_bit_q  <= 1'b0;
         bit_cnt_q   <= '0;
         hit_cnt_q   <= '0;
         y_q         <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         mode_q      <= mode_d;
         win_q       <= win_d;
         run_len_q   <= run_len_d;
         last_bit_q  <= last_bit_d;
         bit_cnt_q   <= bit_cnt_d;
         hit_cnt_q   <= hit_cnt_d;
         y_q         <= y_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
         busy_q      <= busy_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign busy      = busy_q;
   assign y         = y_q;
   assign done      = done_q;
   assign hit_cnt   = hit_cnt_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_run_detect_ctrl.sv
// tb_run_detect_ctrl: table vectors, directed corners and
// random stimulus against a run-history reference model.
module tb_run_detect_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [3:0] cfg_len;
   logic [1:0] cfg_mode;
   logic [7:0] cfg_win;
   logic       start;
   logic       abort;
   logic       x;
   logic       x_valid;
   logic       busy;
   logic       y;
   logic       done;
   logic [7:0] hit_cnt;
   logic       cfg_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   run_detect_ctrl #(.LEN_W(4), .WIN_W(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_len   (cfg_len),
      .cfg_mode  (cfg_mode),
      .cfg_win   (cfg_win),
      .start     (start),
      .abort     (abort),
      .x         (x),
      .x_valid   (x_valid),
      .busy      (busy),
      .y         (y),
      .done      (done),
      .hit_cnt   (hit_cnt),
      .cfg_err   (cfg_err)
   );

   // Reference model: phase 0 armed, 1 running, 2 done.
   int       m_ph;
   int       m_len;
   bit [1:0] m_mode;
   int       m_win;
   int       m_cnt;
   bit       m_hist[$];
   logic     e_y, e_done, e_busy, e_ready, e_err;
   logic [7:0] e_cnt;

   function automatic void model_step();
      bit hit;
      int n;
      e_y   = 1'b0;
      e_err = 1'b0;
      if (rst) begin
         m_ph = 0; m_len = 3; m_mode = 2'b11;
         m_win = 0; m_cnt = 0; m_hist.delete();
      end else if (m_ph == 0) begin
         if (cfg_valid) begin
            if (cfg_len < 2 || cfg_mode == 2'b00) begin
               e_err = 1'b1;
            end else begin
               m_len = cfg_len; m_mode = cfg_mode;
               m_win = cfg_win;
            end
         end
         if (start) begin
            m_ph = 1; m_cnt = 0; m_hist.delete();
         end
      end else if (m_ph == 1) begin
         if (x_valid) begin
            m_hist.push_back(x);
            n = m_hist.size();
            hit = (n >= m_len);
            if (hit) begin
               for (int k = 1; k <= m_len; k++) begin
                  if (m_hist[n-k] != x) hit = 0;
               end
            end
            if (x && !m_mode[0]) hit = 0;
            if (!x && !m_mode[1]) hit = 0;
            e_y = hit;
            if (hit && m_cnt < 255) m_cnt++;
            if (n == ((m_win == 0) ? 256 : m_win)) m_ph = 2;
         end
         if (abort) m_ph = 0;
      end else begin
         m_ph = 0;
      end
      e_done  = (m_ph == 2);
      e_busy  = (m_ph == 1);
      e_ready = (m_ph == 0);
      e_cnt   = 8'(m_cnt);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h",
                  nm, $time, act, exp);
      end
   endtask

   task automatic set_idle();
      rst = 0; cfg_valid = 0; cfg_len = 0; cfg_mode = 0;
      cfg_win = 0; start = 0; abort = 0; x = 0; x_valid = 0;
   endtask

   // Apply current inputs over one edge and compare to the model.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("m_y", y, e_y);
      chk("m_done", done, e_done);
      chk("m_busy", busy, e_busy);
      chk("m_ready", cfg_ready, e_ready);
      chk("m_err", cfg_err, e_err);
      chk("m_cnt", hit_cnt, e_cnt);
   endtask

   task automatic sample(input logic b);
      set_idle(); x_valid = 1; x = b;
      tick();
   endtask

   task automatic cfg_start(input logic [3:0] l,
                            input logic [1:0] m,
                            input logic [7:0] w);
      set_idle();
      cfg_valid = 1; cfg_len = l; cfg_mode = m;
      cfg_win = w; start = 1;
      tick();
   endtask

   typedef struct {
      logic       st, cv;
      logic [3:0] len;
      logic [1:0] mode;
      logic [7:0] win;
      logic       ab, xv, xb;
      logic       ey, ed, eb;
      logic [7:0] ec;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(
      input logic st, cv, input logic [3:0] len,
      input logic [1:0] mode, input logic [7:0] win,
      input logic ab, xv, xb, ey, ed, eb,
      input logic [7:0] ec);
      vec_t v;
      v.st = st; v.cv = cv; v.len = len; v.mode = mode;
      v.win = win; v.ab = ab; v.xv = xv; v.xb = xb;
      v.ey = ey; v.ed = ed; v.eb = eb; v.ec = ec;
      tbl.push_back(v);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      // Reset-default window: 5 ones detect 111 overlapping.
      add(1,0,0,0,0, 0,0,0, 0,0,1,0);
      add(0,0,0,0,0, 0,1,1, 0,0,1,0);
      add(0,0,0,0,0, 0,1,1, 0,0,1,0);
      add(0,0,0,0,0, 0,1,1, 1,0,1,1);
      add(0,0,0,0,0, 0,1,1, 1,0,1,2);
      add(0,0,0,0,0, 0,1,1, 1,0,1,3);
      add(0,0,0,0,0, 1,0,0, 0,0,0,3);
      add(0,0,0,0,0, 0,0,0, 0,0,0,3);
      // len 4, zeros only, window 8.
      add(1,1,4,2,8, 0,0,0, 0,0,1,0);
      add(0,0,0,0,0, 0,1,0, 0,0,1,0);
      add(0,0,0,0,0, 0,1,0, 0,0,1,0);
      add(0,0,0,0,0, 0,1,0, 0,0,1,0);
      add(0,0,0,0,0, 0,1,0, 1,0,1,1);
      add(0,0,0,0,0, 0,1,1, 0,0,1,1);
      add(0,0,0,0,0, 0,1,0, 0,0,1,1);
      add(0,0,0,0,0, 0,1,0, 0,0,1,1);
      add(0,0,0,0,0, 0,1,0, 0,1,0,1);
      add(0,0,0,0,0, 0,0,0, 0,0,0,1);
      // Gaps do not break a run.
      add(1,1,3,3,0, 0,0,0, 0,0,1,0);
      add(0,0,0,0,0, 0,1,1, 0,0,1,0);
      add(0,0,0,0,0, 0,1,1, 0,0,1,0);
      add(0,0,0,0,0, 0,0,1, 0,0,1,0);
      add(0,0,0,0,0, 0,0,1, 0,0,1,0);
      add(0,0,0,0,0, 0,1,1, 1,0,1,1);
      add(0,0,0,0,0, 0,0,1, 0,0,1,1);
      add(0,0,0,0,0, 1,0,0, 0,0,0,1);
      // Abort after 5 samples holds the count.
      add(1,1,3,3,16, 0,0,0, 0,0,1,0);
      add(0,0,0,0,0, 0,1,0, 0,0,1,0);
      add(0,0,0,0,0, 0,1,1, 0,0,1,0);
      add(0,0,0,0,0, 0,1,1, 0,0,1,0);
      add(0,0,0,0,0, 0,1,1, 1,0,1,1);
      add(0,0,0,0,0, 0,1,0, 0,0,1,1);
      add(0,0,0,0,0, 1,0,0, 0,0,0,1);
      add(0,0,0,0,0, 0,0,0, 0,0,0,1);

      set_idle();
      rst = 1;
      tick();
      tick();
      chk("rst_ready", cfg_ready, 1'b1);
      chk("rst_cnt", hit_cnt, 8'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         set_idle();
         start = tbl[i].st; cfg_valid = tbl[i].cv;
         cfg_len = tbl[i].len; cfg_mode = tbl[i].mode;
         cfg_win = tbl[i].win; abort = tbl[i].ab;
         x_valid = tbl[i].xv; x = tbl[i].xb;
         tick();
         chk($sformatf("tbl%0d_y", i), y, tbl[i].ey);
         chk($sformatf("tbl%0d_done", i), done, tbl[i].ed);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
         chk($sformatf("tbl%0d_cnt", i), hit_cnt, tbl[i].ec);
      end

      // Rejected configs keep len=5, mode=01, win=6.
      set_idle();
      cfg_valid = 1; cfg_len = 5; cfg_mode = 2'b01; cfg_win = 6;
      tick();
      chk("acc_err", cfg_err, 1'b0);
      set_idle();
      cfg_valid = 1; cfg_len = 1; cfg_mode = 2'b11; cfg_win = 9;
      tick();
      chk("len1_err", cfg_err, 1'b1);
      set_idle();
      tick();
      chk("err_pulse", cfg_err, 1'b0);
      set_idle();
      cfg_valid = 1; cfg_len = 2; cfg_mode = 2'b00; cfg_win = 9;
      tick();
      chk("mode0_err", cfg_err, 1'b1);
      set_idle();
      start = 1;
      tick();
      chk("rej_busy", busy, 1'b1);
      sample(1);
      sample(1);
      set_idle();
      x_valid = 1; x = 1;
      cfg_valid = 1; cfg_len = 2; cfg_mode = 2'b11;
      chk("run_ready", cfg_ready, 1'b0);
      tick();
      chk("run_cfg_err", cfg_err, 1'b0);
      chk("run_cfg_y", y, 1'b0);
      sample(1);
      chk("len5_y4", y, 1'b0);
      sample(1);
      chk("len5_y5", y, 1'b1);
      sample(1);
      chk("win6_done", done, 1'b1);
      chk("win6_cnt", hit_cnt, 8'd2);
      set_idle();
      tick();

      // Abort on the last sample: sample counts, no done.
      cfg_start(3, 2'b11, 3);
      sample(1);
      sample(1);
      set_idle();
      x_valid = 1; x = 1; abort = 1;
      tick();
      chk("ablast_y", y, 1'b1);
      chk("ablast_cnt", hit_cnt, 8'd1);
      chk("ablast_done", done, 1'b0);
      chk("ablast_busy", busy, 1'b0);
      set_idle();
      tick();
      chk("ablast_done2", done, 1'b0);

      // Reset mid-window restores default config.
      cfg_start(4, 2'b01, 6);
      for (int i = 0; i < 4; i++) sample(1);
      chk("pre_rst_cnt", hit_cnt, 8'd1);
      set_idle();
      rst = 1;
      tick();
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_cnt", hit_cnt, 8'd0);
      set_idle();
      start = 1;
      tick();
      sample(0);
      sample(0);
      sample(0);
      chk("dflt_y", y, 1'b1);
      for (int i = 0; i < 5; i++) sample(0);
      chk("dflt_win", busy, 1'b1);
      set_idle();
      abort = 1;
      tick();

      // Full 256-sample window with len 2.
      cfg_start(2, 2'b11, 0);
      for (int i = 0; i < 256; i++) begin
         sample(1);
         if (i == 254) chk("sat_busy", busy, 1'b1);
      end
      chk("sat_done", done, 1'b1);
      chk("sat_cnt", hit_cnt, 8'd255);
      set_idle();
      tick();
      chk("sat_hold", hit_cnt, 8'd255);

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         set_idle();
         rst = ($urandom_range(0, 399) == 0);
         cfg_valid = ($urandom_range(0, 9) == 0);
         cfg_len = 4'($urandom_range(0, 15));
         cfg_mode = 2'($urandom_range(0, 3));
         r = $urandom_range(0, 9);
         if (r == 0) cfg_win = 0;
         else if (r < 6) cfg_win = 8'($urandom_range(1, 20));
         else cfg_win = 8'($urandom_range(21, 60));
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 59) == 0);
         x_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0) x = ~x;
         tick();
         x = dut.x;
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
